// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit: shift-add multiplier and restoring divider,
// one bit per cycle, with sign fix-up and architectural HI/LO result registers.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t               state_r;
    logic [1:0]           op_r;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [WIDTH:0]       rem_r;
    logic                 neg_q_r;
    logic                 neg_r_r;
    logic                 dz_r;
    logic [CW-1:0]        count_r;

    logic                 is_signed_s;
    logic                 is_div_s;
    logic [WIDTH-1:0]     a_mag_s;
    logic [WIDTH-1:0]     b_mag_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [WIDTH+1:0]     div_shift_s;
    logic [WIDTH+1:0]     div_diff_s;
    logic [2*WIDTH-1:0]   prod_fix_s;
    logic [WIDTH-1:0]     fix_hi_s;
    logic [WIDTH-1:0]     fix_lo_s;

    assign is_signed_s = op_r[0];
    assign is_div_s    = op_r[1];
    assign a_mag_s     = (is_signed_s && a_r[WIDTH-1]) ? neg_w(a_r) : a_r;
    assign b_mag_s     = (is_signed_s && b_r[WIDTH-1]) ? neg_w(b_r) : b_r;

    // Multiplier in acc low half, partial product in high half; carry kept in bit WIDTH.
    assign mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                       + (acc_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
    // Restoring step: shift next dividend bit into the partial remainder and trial-subtract.
    assign div_shift_s = {rem_r, acc_r[WIDTH-1]};
    assign div_diff_s  = div_shift_s - {2'b00, b_r};
    assign prod_fix_s  = neg_q_r ? neg_2w(acc_r) : acc_r;

    // Result selection with sign correction applied in FIX.
    always_comb begin
        fix_hi_s = {WIDTH{1'b0}};
        fix_lo_s = {WIDTH{1'b0}};
        if (dz_r) begin
            fix_hi_s = acc_r[2*WIDTH-1:WIDTH];
            fix_lo_s = acc_r[WIDTH-1:0];
        end else if (is_div_s) begin
            fix_hi_s = neg_r_r ? neg_w(rem_r[WIDTH-1:0]) : rem_r[WIDTH-1:0];
            fix_lo_s = neg_q_r ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
        end else begin
            fix_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_fix_s[WIDTH-1:0];
        end
    end

    assign stall = busy;

    // Sequencer FSM with datapath registers and registered status outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r     <= S_IDLE;
            op_r        <= 2'b00;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            acc_r       <= {(2*WIDTH){1'b0}};
            rem_r       <= {(WIDTH+1){1'b0}};
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            dz_r        <= 1'b0;
            count_r     <= {CW{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= {WIDTH{1'b0}};
            lo          <= {WIDTH{1'b0}};
            div_by_zero <= 1'b0;
        end else if (flush) begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_r        <= op;
                        a_r         <= a;
                        b_r         <= b;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        state_r     <= S_PREP;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_PREP: begin
                    a_r     <= a_mag_s;
                    b_r     <= b_mag_s;
                    neg_q_r <= is_signed_s & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                    neg_r_r <= is_signed_s & a_r[WIDTH-1];
                    rem_r   <= {(WIDTH+1){1'b0}};
                    if (is_div_s && (b_r == {WIDTH{1'b0}})) begin
                        dz_r    <= 1'b1;
                        acc_r   <= {a_r, {WIDTH{1'b1}}};
                        state_r <= S_FIX;
                    end else begin
                        dz_r    <= 1'b0;
                        acc_r   <= {{WIDTH{1'b0}}, a_mag_s};
                        count_r <= CW'(WIDTH);
                        state_r <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (is_div_s) begin
                        if (div_diff_s[WIDTH+1]) begin
                            rem_r <= div_shift_s[WIDTH:0];
                        end else begin
                            rem_r <= div_diff_s[WIDTH:0];
                        end
                        acc_r[WIDTH-1:0] <= {acc_r[WIDTH-2:0], ~div_diff_s[WIDTH+1]};
                    end else begin
                        acc_r <= {mul_sum_s, acc_r[WIDTH-1:1]};
                    end
                    count_r <= count_r - CW'(1);
                    if (count_r == CW'(1)) begin
                        state_r <= S_FIX;
                    end else begin
                        state_r <= S_RUN;
                    end
                end
                S_FIX: begin
                    hi      <= fix_hi_s;
                    lo      <= fix_lo_s;
                    if (dz_r) begin
                        div_by_zero <= 1'b1;
                    end else begin
                        div_by_zero <= div_by_zero;
                    end
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_r <= S_DONE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;

    localparam int WIDTH = 32;
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    logic             clock = 1'b0;
    logic             resetn = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       op = 2'b00;
    logic [WIDTH-1:0] a = 32'h0;
    logic [WIDTH-1:0] b = 32'h0;
    logic             flush = 1'b0;
    logic             busy, stall, done, div_by_zero;
    logic [WIDTH-1:0] hi, lo;

    int total = 0;
    int bad = 0;

    muldiv_sequencer #(.WIDTH(WIDTH)) dut (
        .clock(clock), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .stall(stall), .done(done),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    // Starts an operation and returns at the falling edge where done is seen.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int bcyc, output bit ok);
        @(negedge clock);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        bcyc = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) bcyc++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        #1 resetn = 1'b0;
        #2;
        total++;
        if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL reset_hilo got=%h req=0", {hi, lo}); end
        total++;
        if ({busy, stall, done, div_by_zero} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b req=0000", {busy, stall, done, div_by_zero});
        end
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_multu_max();
        int bc; bit ok;
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL multu_timeout got=no_done req=done"); end
        total++;
        if (bc !== 34) begin bad++; $display("FAIL multu_busy_cycles got=%0d req=34", bc); end
        total++;
        if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
            bad++; $display("FAIL multu_result got=%h req=fffffffe00000001", {hi, lo});
        end
        @(negedge clock);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b req=0", done); end
    endtask

    task automatic test_arith();
        logic [1:0]  ops [6] = '{OP_MULT, OP_DIV, OP_DIV, OP_MULT, OP_DIVU, OP_MULT};
        logic [31:0] as  [6] = '{32'hFFFFFFFD, 32'hFFFFFFF9, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bs  [6] = '{32'h5, 32'h2, 32'hFFFFFFFF, 32'h80000000, 32'h10, 32'hFFFFFFFF};
        logic [31:0] ehi [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h40000000, 32'hF, 32'h0};
        logic [31:0] elo [6] = '{32'hFFFFFFF1, 32'hFFFFFFFD, 32'h80000000, 32'h0, 32'h0FFFFFFF, 32'h1};
        int bc; bit ok;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], bc, ok);
            total++;
            if (!ok || hi !== ehi[i] || lo !== elo[i] || div_by_zero !== 1'b0) begin
                bad++;
                $display("FAIL arith_%0d got=done%b %h:%h dz%b req=%h:%h dz0", i, ok, hi, lo, div_by_zero, ehi[i], elo[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int bc; bit ok;
        run_op(OP_DIVU, 32'h12345678, 32'h0, bc, ok);
        total++;
        if (!ok || bc !== 2) begin bad++; $display("FAIL dz_latency got=done%b busy%0d req=busy2", ok, bc); end
        total++;
        if (hi !== 32'h12345678 || lo !== 32'hFFFFFFFF || div_by_zero !== 1'b1) begin
            bad++; $display("FAIL dz_result got=%h:%h dz%b req=12345678:ffffffff dz1", hi, lo, div_by_zero);
        end
        run_op(OP_MULTU, 32'd2, 32'd3, bc, ok);
        total++;
        if (!ok || hi !== 32'h0 || lo !== 32'd6 || div_by_zero !== 1'b0) begin
            bad++; $display("FAIL dz_clear got=%h:%h dz%b req=0:6 dz0", hi, lo, div_by_zero);
        end
    endtask

    task automatic test_flush();
        int bc; bit ok; bit seen;
        run_op(OP_MULTU, 32'h00010000, 32'h00030000, bc, ok);
        total++;
        if (!ok || hi !== 32'h3 || lo !== 32'h0) begin bad++; $display("FAIL flush_setup got=%h:%h req=3:0", hi, lo); end
        @(negedge clock);
        op = OP_MULTU; a = 32'd7; b = 32'd9; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        total++;
        if (busy !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b%b req=00", busy, stall); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen = 1'b1;
            @(negedge clock);
        end
        total++;
        if (seen || hi !== 32'h3 || lo !== 32'h0 || div_by_zero !== 1'b0) begin
            bad++; $display("FAIL flush_keep got=done%b %h:%h dz%b req=done0 3:0 dz0", seen, hi, lo, div_by_zero);
        end
    endtask

    task automatic test_start_while_busy();
        bit ok;
        @(negedge clock);
        op = OP_MULTU; a = 32'd3; b = 32'd4; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clock);
        end
        total++;
        if (!ok || hi !== 32'h0 || lo !== 32'd12) begin
            bad++; $display("FAIL start_ignored got=done%b %h:%h req=0:c", ok, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int bc; bit ok;
        run_op(OP_MULTU, 32'd3, 32'd5, bc, ok);
        total++;
        if (!ok || lo !== 32'd15) begin bad++; $display("FAIL b2b_first got=done%b lo=%h req=f", ok, lo); end
        op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL b2b_no_gap got=busy%b done%b req=busy1 done0", busy, done); end
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clock);
        end
        total++;
        if (!ok || hi !== 32'd2 || lo !== 32'd14) begin
            bad++; $display("FAIL b2b_second got=done%b %h:%h req=2:e", ok, hi, lo);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        op = OP_MULTU; a = 32'd11; b = 32'd13; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        resetn = 1'b0;
        #1;
        total++;
        if ({hi, lo} !== 64'h0 || busy !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL reset_mid got=%h busy%b req=0 busy0", {hi, lo}, busy);
        end
        @(negedge clock);
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_idle got=busy%b done%b req=00", busy, done); end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_arith();
        test_div_zero();
        test_flush();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle multiply/divide controller and datapath for the pipelined CPU. It accepts MULT/MULTU/DIV/DIVU operations from the EXE stage and runs them iteratively: a shift-add multiplier or a restoring divider, one bit per cycle. While an operation is in flight it drives a stall to the pipeline control. Results go to architectural HI/LO registers, which the pipeline reads for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width; also the number of iterations in RUN.

Ports:
clock  in  1  system clock; all state updates on the rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  request to begin an operation; sampled on the rising edge
op  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
a  in  WIDTH  multiplicand or dividend (rs)
b  in  WIDTH  multiplier or divisor (rt)
flush  in  1  pipeline flush; aborts the operation in flight
busy  out  1  operation in flight (PREP, RUN or FIX)
stall  out  1  stall request to pipeline control; equals busy
done  out  1  one-cycle pulse; HI/LO just updated
hi  out  WIDTH  HI register: product upper half or remainder
lo  out  WIDTH  LO register: product lower half or quotient
div_by_zero  out  1  sticky flag; last divide had b == 0

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE; hi=0, lo=0, busy=0, stall=0, done=0, div_by_zero=0. Reset mid-operation abandons the operation and clears HI/LO to 0.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE: start=1 latches op, a and b, clears div_by_zero, and moves to PREP.
- DONE: done=1 for exactly one cycle. start=1 here is accepted like in IDLE (move to PREP); otherwise move to IDLE.
- PREP:
  - Signed ops (MULT, DIV): take the magnitudes of a and b; record the product/quotient sign as a[msb]^b[msb] and the remainder sign as a[msb].
  - Divides with b==0: skip RUN; go straight to FIX with the zero-divide result.
  - Otherwise: load the iteration counter with WIDTH and move to RUN.
- RUN: one iteration per cycle, exactly WIDTH cycles; the counter decrements and RUN exits to FIX at zero.
  - Multiply: 2*WIDTH-bit accumulator using shift-add on the multiplier LSB.
  - Divide: restoring divide, one quotient bit per cycle, remainder register WIDTH+1 bits.
- FIX: apply the sign correction (two's-complement negate where the recorded sign is 1), then move to DONE. HI/LO are written on the edge entering DONE; they are never written at any other time except reset.
- Latency: start sampled at edge 0; PREP → RUN (edges 1..WIDTH) → FIX (edge WIDTH+1) → DONE (edge WIDTH+2). HI/LO are valid after edge WIDTH+2, and done is high in the cycle that follows. Zero-divide latency is 3 edges.
- busy/stall: registered, high exactly while the state is PREP, RUN or FIX. start while busy is ignored, and the latched operands are not disturbed.
- flush=1: forces IDLE on the next edge from any state. HI/LO are unchanged, no done pulse is produced, and div_by_zero is unchanged. flush has priority over start in the same cycle.
- Arithmetic rules:
  - Multiply: hi:lo = full 2*WIDTH-bit product (signed or unsigned).
  - Divide: quotient truncates toward zero; remainder takes the dividend's sign.
  - b==0: lo = all ones, hi = a, div_by_zero=1.
  - DIV of most-negative by -1: lo = most-negative value (wraps), hi=0, no flag.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → busy for 34 cycles, then done pulse with hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1 (-15).
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, div_by_zero=0.
- DIVU a=0x12345678, b=0 → done 3 edges after start; hi=0x12345678, lo=0xFFFFFFFF, div_by_zero=1. A following MULTU 2*3 clears the flag and gives hi=0, lo=6.
- Control events:
  - flush at RUN cycle 10 → busy=0 after the next edge; hi/lo keep their previous values; no done pulse.
  - resetn low mid-RUN → immediate IDLE with hi=lo=0.
  - start asserted in DONE → new operation with no IDLE gap.
